core_exu_div_ctrl: RTL and testbench

Sequencer for the EXU's iterative radix-2 divider, covering DIV, DIVU, REM and REMU. It latches operands and the destination register, then runs 32 restoring-division iterations. It applies the RISC-V special cases and sign fix-up, and returns a one-cycle result pulse with its register write address. While the division is in flight it drives the EXU hold request and accepts a pipeline flush.

---
 rtl/core_exu_div_ctrl.sv | 158 +++++++++++++++
 tb/tb_core_exu_div_ctrl.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_exu_div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU.
// Latency: normal path result pulse 34 cycles after accept, special cases 1 cycle.
// Backpressure: busy_o holds the pipeline while dividing; flush_i aborts at any time.
module core_exu_div_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      op_div_i,
  input  logic                      signed_i,
  input  logic [DATA_WIDTH-1:0]     dividend_i,
  input  logic [DATA_WIDTH-1:0]     divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic                      result_vld_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_op_div;
  logic                      r_q_neg;
  logic                      r_r_neg;
  logic [DATA_WIDTH-1:0]     r_divisor;
  logic [DATA_WIDTH-1:0]     r_rem;
  logic [DATA_WIDTH-1:0]     r_quo;
  logic [DATA_WIDTH-1:0]     r_result;
  logic                      r_vld;
  logic [REG_ADDR_WIDTH-1:0] r_waddr;

  // Operand conditioning on the raw request. The sign mode is folded into
  // q_neg/r_neg at accept time, so it needs no register of its own.
  logic                  w_dvd_neg;
  logic                  w_dvs_neg;
  logic [DATA_WIDTH-1:0] w_dvd_abs;
  logic [DATA_WIDTH-1:0] w_dvs_abs;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic                  w_special;
  logic [DATA_WIDTH-1:0] w_spec_res;

  assign w_dvd_neg  = signed_i & dividend_i[DATA_WIDTH-1];
  assign w_dvs_neg  = signed_i & divisor_i[DATA_WIDTH-1];
  assign w_dvd_abs  = w_dvd_neg ? -dividend_i : dividend_i;
  assign w_dvs_abs  = w_dvs_neg ? -divisor_i : divisor_i;
  assign w_div_zero = (divisor_i == '0);
  assign w_ovf      = signed_i
                    & (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                    & (divisor_i == '1);
  assign w_special  = w_div_zero | w_ovf;
  // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend (MIN), r = 0.
  assign w_spec_res = w_div_zero ? (op_div_i ? '1 : dividend_i)
                                 : (op_div_i ? dividend_i : '0);

  // One restoring step: shift {rem,quo} left, trial-subtract on a width+1 path.
  // The remainder stays below the divisor, so it fits back into DATA_WIDTH bits.
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH-1:0] w_fix_quo;
  logic [DATA_WIDTH-1:0] w_fix_rem;

  assign w_shift   = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_divisor};
  assign w_fix_quo = r_q_neg ? -r_quo : r_quo;
  assign w_fix_rem = r_r_neg ? -r_rem : r_rem;

  // Hold request: asserted from the accept cycle through FIX, dropped on flush
  // and while reset is held so a stray start cannot stall the pipeline.
  assign busy_o = rst_n_i & ~flush_i &
                  ((r_state == S_CALC) | (r_state == S_FIX) |
                   ((r_state == S_IDLE) & start_i));

  assign result_o     = r_result;
  assign result_vld_o = r_vld;
  assign reg_waddr_o  = r_waddr;

  // Sequencer: accept/latch, iterate, sign fix-up, one-cycle result pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op_div  <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
      r_vld     <= 1'b0;
      r_waddr   <= '0;
    end else begin
      // The pulse lasts exactly the DONE cycle; a flush in DONE cannot retract it.
      r_vld <= 1'b0;
      if (flush_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_op_div  <= op_div_i;
              r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
              r_r_neg   <= w_dvd_neg;
              r_waddr   <= reg_waddr_i;
              r_divisor <= w_dvs_abs;
              r_quo     <= w_dvd_abs;
              r_rem     <= '0;
              if (w_special) begin
                r_result <= w_spec_res;
                r_vld    <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_cnt   <= CNT_W'(DATA_WIDTH - 1);
                r_state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            if (!w_diff[DATA_WIDTH]) begin
              r_rem <= w_diff[DATA_WIDTH-1:0];
              r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[DATA_WIDTH-1:0];
              r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
            end
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_FIX: begin
            r_result <= r_op_div ? w_fix_quo : w_fix_rem;
            r_vld    <= 1'b1;
            r_state  <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_exu_div_ctrl.sv
// Self-checking bench for core_exu_div_ctrl.
// Expected results are pushed to a scoreboard at issue and popped at the result pulse.
// Latency is measured in cycles from the accept cycle T.
module tb_core_exu_div_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LAT_N = 34;
  localparam int LAT_S = 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i;
  logic          op_div_i;
  logic          signed_i;
  logic [DW-1:0] dividend_i;
  logic [DW-1:0] divisor_i;
  logic [AW-1:0] reg_waddr_i;
  logic          flush_i;
  logic          busy_o;
  logic [DW-1:0] result_o;
  logic          result_vld_o;
  logic [AW-1:0] reg_waddr_o;

  typedef struct {
    logic [DW-1:0] res;
    logic [AW-1:0] waddr;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt;
  int   cyc = 0;
  int   t_issue;

  core_exu_div_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .op_div_i     (op_div_i),
    .signed_i     (signed_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .reg_waddr_i  (reg_waddr_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .result_o     (result_o),
    .result_vld_o (result_vld_o),
    .reg_waddr_o  (reg_waddr_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model using the language's truncating division plus RISC-V special cases.
  function automatic logic [DW-1:0] ref_res(input logic od, input logic sg,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb_v;
    if (b == '0) return od ? '1 : a;
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return od ? a : '0;
      sa   = $signed(a);
      sb_v = $signed(b);
      return od ? DW'(sa / sb_v) : DW'(sa % sb_v);
    end
    return od ? a / b : a % b;
  endfunction

  function automatic int ref_lat(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (b == '0) return LAT_S;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_S;
    return LAT_N;
  endfunction

  // Drive one request for a single cycle (cycle T), then scramble the inputs.
  task automatic issue(input logic od, input logic sg, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [AW-1:0] wa,
                       input logic [DW-1:0] res, input int lat);
    exp_t e;
    @(negedge clk_i);
    op_div_i    = od;
    signed_i    = sg;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = wa;
    start_i     = 1'b1;
    t_issue     = cyc;
    e.res = res; e.waddr = wa; e.lat = lat;
    sb.push_back(e);
    #1;
    busy_cnt = busy_o ? 1 : 0;
    @(negedge clk_i);
    start_i     = 1'b0;
    op_div_i    = 1'($urandom);
    signed_i    = 1'($urandom);
    dividend_i  = $urandom;
    divisor_i   = $urandom;
    reg_waddr_i = AW'($urandom);
  endtask

  // Wait (bounded) for the result pulse; lat is cycles since T, -1 on timeout.
  task automatic wait_vld(input int first, input int budget, output int lat);
    int c;
    c   = first;
    lat = -1;
    while (lat < 0 && c <= budget) begin
      if (result_vld_o === 1'b1) begin
        lat = c;
      end else begin
        busy_cnt += (busy_o === 1'b1) ? 1 : 0;
        @(negedge clk_i);
        c++;
      end
    end
  endtask

  // Count result pulses seen over n cycles.
  task automatic count_vld(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (result_vld_o !== 1'b0) seen++;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    start_i = 1'b1;
    op_div_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    reg_waddr_i = 5'd3; flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || result_vld_o !== 1'b0 || result_o !== '0 || reg_waddr_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b vld=%b res=%h waddr=%0d, want all 0",
               busy_o, result_vld_o, result_o, reg_waddr_o);
    end
    start_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || result_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b vld=%b, want 0 0", busy_o, result_vld_o);
    end
  endtask

  task automatic test_unsigned();
    logic [DW-1:0] ta[3] = '{32'd100, 32'd100, 32'hFFFF_FFFF};
    logic [DW-1:0] tb[3] = '{32'd7, 32'd7, 32'd1};
    logic          to[3] = '{1'b1, 1'b0, 1'b1};
    logic [DW-1:0] tr[3] = '{32'd14, 32'd2, 32'hFFFF_FFFF};
    exp_t e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(to[i], 1'b0, ta[i], tb[i], AW'(5 + i), tr[i], LAT_N);
      wait_vld(1, 60, lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
        errors++; $display("FAIL unsigned[%0d] latency: got %0d want %0d", i, lat, e.lat);
      end else begin
        checks++;
        if (result_o !== e.res) begin
          errors++; $display("FAIL unsigned[%0d] result: got %h want %h", i, result_o, e.res);
        end
        checks++;
        if (reg_waddr_o !== e.waddr) begin
          errors++; $display("FAIL unsigned[%0d] waddr: got %0d want %0d", i, reg_waddr_o, e.waddr);
        end
        checks++;
        if (busy_cnt !== e.lat || busy_o !== 1'b0) begin
          errors++; $display("FAIL unsigned[%0d] busy: cycles %0d want %0d, in DONE %b want 0",
                             i, busy_cnt, e.lat, busy_o);
        end
        @(negedge clk_i);
        checks++;
        if (result_vld_o !== 1'b0) begin
          errors++; $display("FAIL unsigned[%0d] pulse_width: vld=%b after DONE, want 0", i, result_vld_o);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [DW-1:0] ta[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C};
    logic [DW-1:0] tb[4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
    logic          to[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] tr[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd14};
    exp_t e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(to[i], 1'b1, ta[i], tb[i], AW'(10 + i), tr[i], LAT_N);
      wait_vld(1, 60, lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
        errors++; $display("FAIL signed[%0d] latency: got %0d want %0d", i, lat, e.lat);
      end else begin
        checks++;
        if (result_o !== e.res || reg_waddr_o !== e.waddr) begin
          errors++; $display("FAIL signed[%0d] result: got %h/%0d want %h/%0d",
                             i, result_o, reg_waddr_o, e.res, e.waddr);
        end
        @(negedge clk_i);
        checks++;
        if (result_vld_o !== 1'b0) begin
          errors++; $display("FAIL signed[%0d] pulse_width: vld=%b after DONE, want 0", i, result_vld_o);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [DW-1:0] ta[5] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [DW-1:0] tb[5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic          to[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic          ts[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] tr[5] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'hFFFF_FFF0};
    exp_t e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(to[i], ts[i], ta[i], tb[i], AW'(20 + i), tr[i], LAT_S);
      wait_vld(1, 60, lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
        errors++; $display("FAIL special[%0d] latency: got %0d want %0d", i, lat, e.lat);
      end else begin
        checks++;
        if (result_o !== e.res || reg_waddr_o !== e.waddr) begin
          errors++; $display("FAIL special[%0d] result: got %h/%0d want %h/%0d",
                             i, result_o, reg_waddr_o, e.res, e.waddr);
        end
        checks++;
        if (busy_cnt !== 1 || busy_o !== 1'b0) begin
          errors++; $display("FAIL special[%0d] busy: cycles %0d want 1, in DONE %b want 0",
                             i, busy_cnt, busy_o);
        end
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int lat;
    int seen;
    // Flush mid-CALC at T+10, new op at T+12.
    issue(1'b1, 1'b0, 32'd1000, 32'd3, 5'd3, 32'd333, LAT_N);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_busy: busy=%b in flush cycle, want 0", busy_o);
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (busy_o !== 1'b0 || result_vld_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle: busy=%b vld=%b at T+11, want 0 0", busy_o, result_vld_o);
    end
    issue(1'b1, 1'b0, 32'd9, 32'd3, 5'd4, 32'd3, LAT_N);
    wait_vld(1, 60, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || result_o !== e.res || reg_waddr_o !== e.waddr) begin
      errors++; $display("FAIL flush_next: lat %0d res %h waddr %0d, want lat %0d res %h waddr %0d",
                         lat, result_o, reg_waddr_o, e.lat, e.res, e.waddr);
    end
    // Flush in FIX (T+33): the result must never appear.
    @(negedge clk_i);
    issue(1'b1, 1'b0, 32'd77, 32'd7, 5'd6, 32'd11, LAT_N);
    repeat (32) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    void'(sb.pop_back());
    count_vld(40, seen);
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_fix: %0d result pulses after flush in FIX, want 0", seen);
    end
    // Start together with flush in IDLE: nothing accepted.
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1;
    op_div_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd8; divisor_i = 32'd2;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_start_busy: busy=%b, want 0", busy_o);
    end
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    count_vld(40, seen);
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_start: %0d result pulses, want 0", seen);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int lat;
    int seen;
    issue(1'b1, 1'b0, 32'd50, 32'd5, 5'd7, 32'd10, LAT_N);
    repeat (4) @(negedge clk_i);
    start_i = 1'b1; op_div_i = 1'b0; signed_i = 1'b1;
    dividend_i = 32'd7; divisor_i = 32'd7; reg_waddr_i = 5'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_vld(6, 60, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || result_o !== e.res || reg_waddr_o !== e.waddr) begin
      errors++; $display("FAIL ignore_start: lat %0d res %h waddr %0d, want lat %0d res %h waddr %0d",
                         lat, result_o, reg_waddr_o, e.lat, e.res, e.waddr);
    end
    count_vld(40, seen);
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL ignore_start_queue: %0d extra result pulses, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    int t_a;
    issue(1'b1, 1'b0, 32'd100, 32'd7, 5'd1, 32'd14, LAT_N);
    t_a = t_issue;
    wait_vld(1, 60, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || result_o !== e.res) begin
      errors++; $display("FAIL b2b_first: lat %0d res %h, want lat %0d res %h", lat, result_o, e.lat, e.res);
    end
    issue(1'b0, 1'b0, 32'd100, 32'd7, 5'd2, 32'd2, LAT_N);
    checks++;
    if (busy_cnt !== 1 || (t_issue - t_a) !== 35) begin
      errors++; $display("FAIL b2b_accept: busy at T=%0d interval %0d, want 1 and 35", busy_cnt, t_issue - t_a);
    end
    wait_vld(1, 60, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || result_o !== e.res || reg_waddr_o !== e.waddr) begin
      errors++; $display("FAIL b2b_second: lat %0d res %h waddr %0d, want lat %0d res %h waddr %0d",
                         lat, result_o, reg_waddr_o, e.lat, e.res, e.waddr);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    logic od, sg;
    logic [DW-1:0] a, b;
    logic [AW-1:0] wa;
    for (int i = 0; i < 16; i++) begin
      od = 1'($urandom); sg = 1'($urandom);
      a  = $urandom;
      wa = AW'($urandom);
      case (i % 4)
        0: b = 32'($urandom_range(1, 100));
        1: b = $urandom;
        2: b = (i == 2) ? 32'd0 : 32'($urandom_range(1, 9));
        default: b = {16'hFFFF, 16'($urandom)};
      endcase
      issue(od, sg, a, b, wa, ref_res(od, sg, a, b), ref_lat(sg, a, b));
      wait_vld(1, 60, lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || result_o !== e.res || reg_waddr_o !== e.waddr) begin
        errors++; $display("FAIL random[%0d] od=%b sg=%b %h/%h: lat %0d res %h waddr %0d, want lat %0d res %h waddr %0d",
                           i, od, sg, a, b, lat, result_o, reg_waddr_o, e.lat, e.res, e.waddr);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat;
    int seen;
    issue(1'b1, 1'b0, 32'd123456, 32'd7, 5'd17, 32'd17636, LAT_N);
    repeat (10) @(negedge clk_i);
    rst_n_i = 1'b0;
    start_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || result_vld_o !== 1'b0 || result_o !== '0 || reg_waddr_o !== '0) begin
      errors++; $display("FAIL reset_mid: busy=%b vld=%b res=%h waddr=%0d, want all 0",
                         busy_o, result_vld_o, result_o, reg_waddr_o);
    end
    void'(sb.pop_back());
    @(negedge clk_i);
    start_i = 1'b0;
    rst_n_i = 1'b1;
    count_vld(40, seen);
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_mid_ghost: %0d result pulses after reset, want 0", seen);
    end
    issue(1'b1, 1'b0, 32'd9, 32'd3, 5'd8, 32'd3, LAT_N);
    wait_vld(1, 60, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || result_o !== e.res || reg_waddr_o !== e.waddr) begin
      errors++; $display("FAIL reset_recover: lat %0d res %h waddr %0d, want lat %0d res %h waddr %0d",
                         lat, result_o, reg_waddr_o, e.lat, e.res, e.waddr);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
